// File: rtl/rt_var_delay_buf.sv
// Runtime-variable delay line for a data+valid stream, built on a circular buffer.
// A fill counter masks reads of slots not yet written since reset.
module rt_var_delay_buf #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_DELAY   = 32,
    parameter int DELAY_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic [DELAY_WIDTH-1:0] delay,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   delay_clamped
);

    localparam int DEPTH = 2 ** DELAY_WIDTH;
    localparam logic [DELAY_WIDTH-1:0] MAX_D = DELAY_WIDTH'(MAX_DELAY);

    // The read slot must never alias the slot being written on the same edge.
    generate
        if (DEPTH < MAX_DELAY + 1 || MAX_DELAY < 1) begin : g_param_check
            $error("rt_var_delay_buf: need MAX_DELAY >= 1 and 2**DELAY_WIDTH >= MAX_DELAY+1");
        end
    endgenerate

    logic [DATA_WIDTH:0]    mem [DEPTH];
    logic [DELAY_WIDTH-1:0] wr_ptr;
    logic [DELAY_WIDTH-1:0] fill_cnt;
    logic [DELAY_WIDTH-1:0] eff_delay;
    logic [DELAY_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH:0]    rd_word;
    logic                   clamp;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        clamp     = (delay > MAX_D);
        eff_delay = clamp ? MAX_D : delay;
        rd_addr   = wr_ptr - eff_delay;
        rd_word   = mem[rd_addr];
    end

    // NOTE: the buffer RAM has no reset; fill_cnt guarantees unwritten slots are never emitted.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[wr_ptr] <= {in_valid, in_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the asynchronous read sees pre-edge contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            delay_clamped <= 1'b0;
        end else if (en) begin
            wr_ptr        <= wr_ptr + 1'b1;
            delay_clamped <= clamp;
            if (fill_cnt != MAX_D) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (eff_delay == '0) begin
                out_data  <= in_data;
                out_valid <= in_valid;
            end else if (fill_cnt >= eff_delay) begin
                out_data  <= rd_word[DATA_WIDTH-1:0];
                out_valid <= rd_word[DATA_WIDTH];
            end else begin
                out_data  <= '0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rt_var_delay_buf.sv
// Directed bench for rt_var_delay_buf: hand-computed vector table plus
// multi-cycle sequences checked against a sample-history model.
module tb_rt_var_delay_buf;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] in_data;
    logic       in_valid;
    logic [5:0] delay;
    logic [7:0] out_data;
    logic       out_valid;
    logic       delay_clamped;

    rt_var_delay_buf #(
        .DATA_WIDTH (8),
        .MAX_DELAY  (32),
        .DELAY_WIDTH(6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .delay        (delay),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .delay_clamped(delay_clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] din;
        logic       vin;
        logic [5:0] dly;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_clamp;
    } vec_t;

    vec_t vecs [21];

    int n_checks = 0;
    int n_fail   = 0;

    // Sample-history model: every enabled sample since reset, in order.
    logic [8:0] hist [0:1023];
    int         n_hist;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_clamp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string name);
        check({name, ".data"},  32'(out_data),      32'(exp_data));
        check({name, ".valid"}, 32'(out_valid),     32'(exp_valid));
        check({name, ".clamp"}, 32'(delay_clamped), 32'(exp_clamp));
    endtask

    task automatic model_reset();
        n_hist    = 0;
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_clamp = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive, wait for the edge, update the model, compare.
    task automatic mstep(input logic e, input logic [7:0] di, input logic vi,
                         input logic [5:0] dl, input string name);
        int d;
        en       = e;
        in_data  = di;
        in_valid = vi;
        delay    = dl;
        @(posedge clk);
        #1;
        if (e) begin
            d         = (dl > 6'd32) ? 32 : int'(dl);
            exp_clamp = (dl > 6'd32);
            if (d == 0) {exp_valid, exp_data} = {vi, di};
            else if (n_hist >= d) {exp_valid, exp_data} = hist[n_hist - d];
            else {exp_valid, exp_data} = 9'h000;
            hist[n_hist] = {vi, di};
            n_hist++;
        end
        check_outputs(name);
    endtask

    initial begin
        logic [7:0] prev;
        logic [7:0] diff;

        // d=0: single register stage
        vecs[0]  = '{1'b1, 1'b1, 8'h01, 1'b1, 6'd0, 8'h01, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 6'd0, 8'h02, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h03, 1'b1, 6'd0, 8'h03, 1'b1, 1'b0};
        // d=5 fill masking: first five edges masked, ramp emerges on the sixth
        vecs[3]  = '{1'b1, 1'b1, 8'h10, 1'b1, 6'd5, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b1, 6'd5, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h12, 1'b1, 6'd5, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h13, 1'b1, 6'd5, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h14, 1'b1, 6'd5, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h15, 1'b1, 6'd5, 8'h10, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h16, 1'b1, 6'd5, 8'h11, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h17, 1'b1, 6'd5, 8'h12, 1'b1, 1'b0};
        // d=3 with enable gaps; 0xEE on disabled cycles must never be stored
        vecs[11] = '{1'b1, 1'b1, 8'h20, 1'b1, 6'd3, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'hEE, 1'b1, 6'd3, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'h21, 1'b1, 6'd3, 8'h00, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 8'h22, 1'b0, 6'd3, 8'h00, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 8'hEE, 1'b1, 6'd3, 8'h00, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 8'h23, 1'b1, 6'd3, 8'h20, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 8'h24, 1'b1, 6'd3, 8'h21, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 8'h25, 1'b1, 6'd3, 8'h22, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 8'hEE, 1'b1, 6'd50, 8'h22, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 8'h26, 1'b1, 6'd3, 8'h23, 1'b1, 1'b0};

        rst_n    = 1'b0;
        en       = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        delay    = 6'd0;
        model_reset();
        #1;
        check_outputs("reset_state");
        #11;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].rst) do_reset();
            en       = vecs[i].en;
            in_data  = vecs[i].din;
            in_valid = vecs[i].vin;
            delay    = vecs[i].dly;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.data", i),  32'(out_data),      32'(vecs[i].exp_data));
            check($sformatf("vec%0d.valid", i), 32'(out_valid),     32'(vecs[i].exp_valid));
            check($sformatf("vec%0d.clamp", i), 32'(delay_clamped), 32'(vecs[i].exp_clamp));
        end

        // Delay decrease 10 -> 4: six samples skipped, output jumps by 7
        do_reset();
        prev = 8'h00;
        for (int i = 0; i < 50; i++) begin
            prev = out_data;
            mstep(1'b1, 8'(i), 1'b1, (i < 30) ? 6'd10 : 6'd4, "dec_delay");
            if (i == 30) begin
                diff = out_data - prev;
                check("dec_skip", 32'(diff), 32'd7);
            end
        end

        // Delay increase 4 -> 20 with only 12 samples written
        do_reset();
        for (int i = 0; i < 30; i++) begin
            mstep(1'b1, 8'(8'h80 + i), 1'b1, (i < 12) ? 6'd4 : 6'd20, "inc_delay");
            if (i == 19) check("inc_masked", 32'(out_valid), 32'd0);
            if (i == 20) check("inc_resume", 32'({out_valid, out_data}), 32'h180);
        end

        // Clamp: delay 50 behaves as 32 (33-cycle latency), then delay 7 clears the flag
        do_reset();
        for (int i = 0; i < 40; i++) begin
            mstep(1'b1, 8'(8'h40 + i), 1'b1, 6'd50, "clamp50");
            if (i == 32) check("clamp_latency", 32'({delay_clamped, out_valid, out_data}), 32'h340);
        end
        for (int i = 0; i < 3; i++) begin
            mstep(1'b1, 8'(8'h68 + i), 1'b1, 6'd7, "clamp_off");
        end

        // Pointer wrap: well over three trips around the 64-entry buffer
        do_reset();
        for (int i = 0; i < 210; i++) begin
            mstep(1'b1, 8'(i), (i % 7) != 0, (i < 200) ? 6'd32 : 6'd40, "wrap");
        end

        // Asynchronous reset mid-cycle: outputs clear before any edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.data",  32'(out_data),      32'd0);
        check("async_rst.valid", 32'(out_valid),     32'd0);
        check("async_rst.clamp", 32'(delay_clamped), 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            mstep(1'b1, 8'(8'h10 + i), 1'b1, 6'd5, "post_rst_fill");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
